// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, one full-subtractor bit per clock, start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             borrowout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic [CW-1:0]    cnt;
  logic             br, d, br_next, last;

  always_comb begin
    d          = a_sh[0] ^ b_sh[0] ^ br;
    br_next    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    r_next     = {d, r_sh[WIDTH-1:1]};
    last       = cnt == LAST;
    state_next = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) : IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_next;

  // Y/borrowout only move on the final RUN edge so they hold the last result otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      Y         <= '0;
      borrowout <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh <= A;
      b_sh <= B;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_next;
      br   <= br_next;
      cnt  <= cnt + 1'b1;
      if (last) begin
        Y         <= r_next;
        borrowout <= br_next;
      end
    end
  end

  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed table, corner sequences, exhaustive and random checks vs arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0, reset, start, borrowout, busy, done;
  logic [W-1:0] A, B, Y;
  int           passed = 0, total = 0;
  int           lat, busy_cnt, post_done, post_busy;
  logic [W-1:0] r_y;
  logic         r_bo;

  typedef struct {
    logic [W-1:0] a, b, y;
    logic         bo;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .Y(Y), .borrowout(borrowout), .busy(busy), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge with the DUT idle; returns latency, result and post-done status.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y_prev;
    y_prev   = Y;
    lat      = -1;
    busy_cnt = 0;
    start = 1'b1; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0; A = ~a; B = W'($urandom);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) lat = c;
      if (c == 2) check("hold_during_run", Y, y_prev);
    end
    if (lat < 0) $display("FAIL timeout: got no done expected done within 20 cycles");
    r_y  = Y;
    r_bo = borrowout;
    @(negedge clk);
    post_done = done;
    post_busy = busy;
  endtask

  initial begin
    int dones, last_t, t;
    logic [W-1:0] a, b, held;
    vecs[0] = '{a: 4'd5,  b: 4'd3,  y: 4'd2,  bo: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  y: 4'd14, bo: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd1,  y: 4'd15, bo: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, y: 4'd0,  bo: 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    check("reset_y", Y, 0);
    check("reset_bo", borrowout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b);
      check("dir_y", r_y, vecs[i].y);
      check("dir_bo", r_bo, vecs[i].bo);
      check("dir_latency", lat, W + 1);
      check("dir_busy_cycles", busy_cnt, W + 1);
      check("dir_done_one_cycle", post_done, 0);
      check("dir_idle_after", post_busy, 0);
    end

    // second start during RUN must be ignored
    start = 1'b1; A = 4'd9; B = 4'd4;
    @(posedge clk);
    #1 start = 1'b0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        r_y = Y; r_bo = borrowout;
      end
    end
    check("ign_done_count", dones, 1);
    check("ign_y", r_y, 5);
    check("ign_bo", r_bo, 0);

    // asynchronous reset in the 3rd RUN cycle discards the operation
    start = 1'b1; A = 4'd12; B = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_y", Y, 0);
    check("rst_mid_bo", borrowout, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
    run_op(4'd7, 4'd2);
    check("post_rst_y", r_y, 5);
    check("post_rst_bo", r_bo, 0);

    // start held high: one accept every W+2 cycles, Y stable between completions
    held = Y;
    start = 1'b1; A = 4'd6; B = 4'd6;
    dones = 0; last_t = -1;
    for (t = 1; t <= 4 * (W + 2); t++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("held_y", Y, 0);
        check("held_bo", borrowout, 0);
        if (last_t >= 0) check("held_interval", t - last_t, W + 2);
        else check("held_first_latency", t, W + 1);
        last_t = t;
        held = Y;
      end else check("held_y_stable", Y, held);
    end
    start = 1'b0;
    check("held_done_count", dones, 4);
    @(negedge clk); @(negedge clk);

    // exhaustive sweep against plain arithmetic
    for (int i = 0; i < 256; i++) begin
      a = W'(i >> 4);
      b = W'(i);
      run_op(a, b);
      check("sweep_y", r_y, int'(W'(a - b)));
      check("sweep_bo", r_bo, int'(a < b));
      check("sweep_latency", lat, W + 1);
    end

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b);
      check("rand_y", r_y, (int'(a) - int'(b) + (1 << W)) % (1 << W));
      check("rand_bo", r_bo, int'(a < b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
